bus_system_reg: RTL
===================

Name: bus_system_reg

Overview:
- Parametrised, registered successor to the datapath bus system. Selects one of N_SRC source words from a one-hot drive-enable vector using a lowest-index priority encoder, and presents the selection on a registered bus output.
- Adds several behaviours the combinational bus lacks: bus-keeper (hold) or zero-idle mode, valid flag, encoded-select readout, multi-driver contention detection, and a saturating contention counter.
- Sits between the register file / special registers (HI, LO, Z, PC, MDR, InPort, C) and all bus consumers.

Parameters:
- DATA_W, 32, width of each source word and of bus_out.
- N_SRC, 24, number of bus sources (2..32).
- SEL_W, 5, width of the encoded select; must satisfy 2**SEL_W >= N_SRC.
- KEEP, 1, 1 = bus_out holds its last value when no source drives; 0 = bus_out goes to 0.
- CNT_W, 8, width of the contention counter.

Ports:
- clock  input  1  rising-edge clock.
- clear  input  1  synchronous active-high reset.
- drive  input  N_SRC  per-source out-enable; bit i selects source i.
- bus_in  input  N_SRC*DATA_W  flattened sources; source i occupies bits [i*DATA_W +: DATA_W].
- cnt_clr  input  1  synchronous clear of the contention counter and sticky flag.
- bus_out  output  DATA_W  registered bus value.
- bus_valid  output  1  high when bus_out was loaded from a source on the previous edge.
- sel_code  output  SEL_W  registered index of the winning source; 0 when none.
- contention  output  1  registered pulse: more than one drive bit was high on the previous edge.
- contention_sticky  output  1  set by any contention; cleared only by clear or cnt_clr.
- contention_cnt  output  CNT_W  saturating count of contention cycles.

Behaviour:
- Reset (clear=1 at an edge): bus_out=0, bus_valid=0, sel_code=0, contention=0, contention_sticky=0, contention_cnt=0.
  - clear has priority over every other input, including mid-transfer and simultaneous cnt_clr.
- Latency: exactly 1 clock. Inputs sampled at edge k appear on all outputs after edge k.
- Selection: winner = lowest index i with drive[i]=1.
  - bus_out <= bus_in slice[winner]; sel_code <= winner; bus_valid <= 1.
- No driver (drive == 0):
  - bus_valid <= 0 and sel_code <= 0.
  - bus_out holds its previous value if KEEP=1; bus_out <= 0 if KEEP=0.
- Contention (popcount(drive) >= 2):
  - The lowest-index source still wins.
  - contention <= 1 for one cycle per contending cycle.
  - contention_sticky <= 1.
  - contention_cnt increments by 1 and saturates at 2**CNT_W-1 (no wrap).
- Non-contending cycle: contention <= 0; contention_sticky and contention_cnt unchanged.
- cnt_clr=1 (without clear): contention_cnt <= 0 and contention_sticky <= 0.
  - Clear wins over a same-cycle increment, so the count is 0, not 1.
  - contention still reflects the current cycle.
  - Bus path is unaffected.
- Drive bits at index >= N_SRC do not exist. sel_code never exceeds N_SRC-1.
- No combinational path from any input to any output.

Test Plan:
- Reset: clear=1 with drive=all ones, contention present -> after edge all outputs 0. Hold clear 3 cycles -> outputs stay 0.
- Single driver: drive=1<<20, src20=32'hDEADBEEF -> next cycle bus_out=32'hDEADBEEF, sel_code=20, bus_valid=1, contention=0.
- Idle / keeper mode: after the single-driver case, drive=0.
  - KEEP=1: bus_out stays 32'hDEADBEEF, bus_valid=0, sel_code=0.
  - KEEP=0 build: bus_out=0.
- Contention: drive bits 3 and 17 set, src3=32'h11, src17=32'h22 -> bus_out=32'h11, sel_code=3, contention=1, contention_sticky=1, contention_cnt=1. Next cycle with one driver -> contention=0, sticky=1, cnt=1.
- Saturation and counter clear: CNT_W=2, 5 consecutive contending cycles -> cnt=3 (no wrap). Then cnt_clr=1 while contending -> cnt=0, sticky=0, contention=1.
- Scaling: N_SRC=4, DATA_W=8, SEL_W=2; drive=4'b1000, src3=8'hA5 -> bus_out=8'hA5, sel_code=3. Random drive vectors checked against a reference model for 1000 cycles.

Source files
------------

// File: rtl/bus_system_reg.sv
// Registered bus multiplexer: lowest-index priority select over one-hot drive enables,
// with bus keeper, valid flag, encoded select readout and contention monitoring.
module bus_system_reg #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 24,
  parameter int SEL_W  = 5,
  parameter int KEEP   = 1,
  parameter int CNT_W  = 8
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic [N_SRC-1:0]        drive,
  input  logic [N_SRC*DATA_W-1:0] bus_in,
  input  logic                    cnt_clr,
  output logic [DATA_W-1:0]       bus_out,
  output logic                    bus_valid,
  output logic [SEL_W-1:0]        sel_code,
  output logic                    contention,
  output logic                    contention_sticky,
  output logic [CNT_W-1:0]        contention_cnt
);

  logic [SEL_W-1:0]  win_idx;
  logic [DATA_W-1:0] win_data;
  logic              any_drive;
  logic              multi_drive;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (drive[i]) begin
        win_idx  = SEL_W'(i);
        win_data = bus_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Clearing the lowest set bit leaves a nonzero value only if two or more bits were set.
  assign any_drive   = |drive;
  assign multi_drive = |(drive & (drive - N_SRC'(1)));

  always_ff @(posedge clock) begin
    if (clear) begin
      bus_out   <= '0;
      bus_valid <= 1'b0;
      sel_code  <= '0;
    end else if (any_drive) begin
      bus_out   <= win_data;
      bus_valid <= 1'b1;
      sel_code  <= win_idx;
    end else begin
      if (KEEP == 0) begin
        bus_out <= '0;
      end
      bus_valid <= 1'b0;
      sel_code  <= '0;
    end
  end

  // A counter clear takes precedence over a same-cycle increment.
  always_ff @(posedge clock) begin
    if (clear) begin
      contention        <= 1'b0;
      contention_sticky <= 1'b0;
      contention_cnt    <= '0;
    end else begin
      contention <= multi_drive;
      if (cnt_clr) begin
        contention_sticky <= 1'b0;
        contention_cnt    <= '0;
      end else if (multi_drive) begin
        contention_sticky <= 1'b1;
        if (contention_cnt != {CNT_W{1'b1}}) begin
          contention_cnt <= contention_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
